// File: rtl/regfile_wb_scoreboard_pkg.sv
// Shared definitions for the register-file writeback controller.
//   NREG / AW / DW     : architectural register count, address and data widths
//   STARVE_LIMIT_DEF   : default number of ALU-blocked cycles before override
//   CW                 : starvation counter width (holds limits 1..15)
//   REG_ZERO           : the hard-wired zero register index
//   wb_req_t           : one writeback request (valid, destination, data)
package regfile_wb_scoreboard_pkg;

    localparam int NREG             = 32;
    localparam int AW               = 5;
    localparam int DW               = 32;
    localparam int STARVE_LIMIT_DEF = 4;
    localparam int CW               = 4;

    localparam logic [AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_scoreboard_wb_arbiter.sv
// Two-requester arbiter for the single register-file write port.
// MEM normally wins; an ALU request that has been blocked for STARVE_LIMIT
// consecutive cycles takes the port on the next cycle it waits.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   alu_req, mem_req    : incoming writeback requests
//   alu_ready, mem_ready: grants (combinational from valid and counter)
//   grant               : the granted request (valid=0 when nobody wins)
// Handshake: a transfer fires when valid && ready; a requester holds its
// payload stable while valid && !ready.
module regfile_wb_scoreboard_wb_arbiter
    import regfile_wb_scoreboard_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic    clk,
    input  logic    rst_n,
    input  wb_req_t alu_req,
    input  wb_req_t mem_req,
    output logic    alu_ready,
    output logic    mem_ready,
    output wb_req_t grant
);

    localparam logic [CW-1:0] LIMIT = STARVE_LIMIT[CW-1:0];

    logic [CW-1:0] starve_cnt;
    logic          alu_override;

    assign alu_override = (starve_cnt == LIMIT);
    assign mem_ready    = mem_req.valid && !alu_override;
    assign alu_ready    = alu_req.valid && !(mem_req.valid && !alu_override);

    always_comb begin
        grant = '0;
        if (mem_ready) begin
            grant = mem_req;
        end else if (alu_ready) begin
            grant = alu_req;
        end
    end

    // Counts consecutive cycles the ALU waits; saturates so the override
    // stays asserted until the ALU is actually served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!alu_req.valid || alu_ready) begin
            starve_cnt <= '0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + {{(CW-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/regfile_wb_scoreboard.sv
// Controller in front of the 32x32 register file: arbitrates the write port
// between ALU and load writeback, keeps a busy scoreboard of pending
// destinations and stalls issue on RAW/WAW hazards.
// Ports:
//   iss_valid/iss_ready, iss_rs1, iss_rs2, iss_rd, iss_wr : issue handshake
//   alu_valid/alu_ready, alu_rd, alu_data                 : ALU writeback
//   mem_valid/mem_ready, mem_rd, mem_data                 : load writeback
//   rf_we, rf_rd, rf_wdata : registered register-file write port
//   busy_mask              : scoreboard, bit i = register i pending
// Handshake: every channel transfers when valid && ready; the sender holds
// its payload stable while valid && !ready. Issue readiness depends only on
// registered busy bits, so there is no path between issue and writeback
// ready signals.
module regfile_wb_scoreboard #(
    parameter int NREG         = 32,
    parameter int AW           = 5,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iss_valid,
    output logic            iss_ready,
    input  logic [AW-1:0]   iss_rs1,
    input  logic [AW-1:0]   iss_rs2,
    input  logic [AW-1:0]   iss_rd,
    input  logic            iss_wr,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_rd,
    input  logic [DW-1:0]   alu_data,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [AW-1:0]   mem_rd,
    input  logic [DW-1:0]   mem_data,
    output logic            rf_we,
    output logic [AW-1:0]   rf_rd,
    output logic [DW-1:0]   rf_wdata,
    output logic [NREG-1:0] busy_mask
);

    import regfile_wb_scoreboard_pkg::wb_req_t;
    import regfile_wb_scoreboard_pkg::REG_ZERO;

    wb_req_t alu_req;
    wb_req_t mem_req;
    wb_req_t grant;

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] clr_vec;
    logic [NREG-1:0] busy_nxt;

    assign alu_req = '{valid: alu_valid, rd: alu_rd, data: alu_data};
    assign mem_req = '{valid: mem_valid, rd: mem_rd, data: mem_data};

    regfile_wb_scoreboard_wb_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_req   (alu_req),
        .mem_req   (mem_req),
        .alu_ready (alu_ready),
        .mem_ready (mem_ready),
        .grant     (grant)
    );

    // busy_q[0] is held at zero, so x0 operands never stall.
    assign iss_ready = iss_valid
                     && !busy_q[iss_rs1]
                     && !busy_q[iss_rs2]
                     && !(iss_wr && busy_q[iss_rd]);

    assign busy_mask = busy_q;

    // Clear is applied before set so a same-register set/clear leaves it busy.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (iss_ready && iss_wr && (iss_rd != REG_ZERO)) begin
            set_vec[iss_rd] = 1'b1;
        end
        if (grant.valid && (grant.rd != REG_ZERO)) begin
            clr_vec[grant.rd] = 1'b1;
        end
        busy_nxt    = (busy_q & ~clr_vec) | set_vec;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_nxt;
        end
    end

    // Address and data hold when idle; only the enable drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else if (grant.valid) begin
            rf_we    <= (grant.rd != REG_ZERO);
            rf_rd    <= grant.rd;
            rf_wdata <= grant.data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
module tb_regfile_wb_scoreboard;

    localparam int NREG  = 32;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int SLIM  = 4;
    localparam int EW    = 1 + AW + DW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            iss_valid, iss_ready, iss_wr;
    logic [AW-1:0]   iss_rs1, iss_rs2, iss_rd;
    logic            alu_valid, alu_ready;
    logic [AW-1:0]   alu_rd;
    logic [DW-1:0]   alu_data;
    logic            mem_valid, mem_ready;
    logic [AW-1:0]   mem_rd;
    logic [DW-1:0]   mem_data;
    logic            rf_we;
    logic [AW-1:0]   rf_rd;
    logic [DW-1:0]   rf_wdata;
    logic [NREG-1:0] busy_mask;

    regfile_wb_scoreboard #(
        .NREG(NREG), .AW(AW), .DW(DW), .STARVE_LIMIT(SLIM)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd), .iss_wr(iss_wr),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_rd(mem_rd), .mem_data(mem_data),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .busy_mask(busy_mask)
    );

    int checks = 0;
    int failures = 0;

    // scoreboard of expected write-port loads: {we, rd, data}
    logic [EW-1:0] exp_q[$];

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        iss_valid = 1'b0; iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0; iss_wr = 1'b0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    endtask

    task automatic set_iss(input logic v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                           input logic [AW-1:0] rd, input logic wr);
        iss_valid = v; iss_rs1 = rs1; iss_rs2 = rs2; iss_rd = rd; iss_wr = wr;
    endtask

    task automatic set_alu(input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d);
        alu_valid = v; alu_rd = rd; alu_data = d;
    endtask

    task automatic set_mem(input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d);
        mem_valid = v; mem_rd = rd; mem_data = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy_mask !== '0 || rf_we !== 1'b0 || rf_rd !== '0 || rf_wdata !== '0) begin
            failures++;
            $display("FAIL reset_hold: busy=%h we=%b rd=%0d wd=%h, want all zero", busy_mask, rf_we, rf_rd, rf_wdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        checks++;
        if (busy_mask !== '0 || rf_we !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: busy=%h we=%b, want 0 0", busy_mask, rf_we);
        end

        // build up busy=0x6 and rf_we=1, then reset between edges
        set_iss(1'b1, 5'd0, 5'd0, 5'd1, 1'b1);
        next_cycle();
        set_iss(1'b1, 5'd0, 5'd0, 5'd2, 1'b1);
        set_alu(1'b1, 5'd3, 32'h0000_A5A5);
        next_cycle();
        drive_idle();
        checks++;
        if (busy_mask !== 32'h0000_0006 || rf_we !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_state: busy=%h we=%b, want 00000006 1", busy_mask, rf_we);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy_mask !== '0 || rf_we !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: busy=%h we=%b, want 0 0", busy_mask, rf_we);
        end
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_raw_stall();
        set_iss(1'b1, 5'd0, 5'd0, 5'd5, 1'b1);
        settle();
        checks++;
        if (iss_ready !== 1'b1) begin
            failures++;
            $display("FAIL raw_first_issue: iss_ready=%b want 1", iss_ready);
        end
        next_cycle();
        checks++;
        if (busy_mask !== 32'h0000_0020) begin
            failures++;
            $display("FAIL raw_busy_set: busy=%h want 00000020", busy_mask);
        end
        set_iss(1'b1, 5'd5, 5'd0, 5'd6, 1'b1);
        set_alu(1'b1, 5'd5, 32'hDEAD_BEEF);
        settle();
        checks++;
        if (iss_ready !== 1'b0 || alu_ready !== 1'b1) begin
            failures++;
            $display("FAIL raw_stall: iss_ready=%b alu_ready=%b want 0 1", iss_ready, alu_ready);
        end
        next_cycle();
        set_alu(1'b0, 5'd0, 32'h0);
        checks++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_wdata !== 32'hDEAD_BEEF || busy_mask !== '0) begin
            failures++;
            $display("FAIL raw_writeback: we=%b rd=%0d wd=%h busy=%h want 1 5 deadbeef 0",
                     rf_we, rf_rd, rf_wdata, busy_mask);
        end
        settle();
        checks++;
        if (iss_ready !== 1'b1) begin
            failures++;
            $display("FAIL raw_release: iss_ready=%b want 1", iss_ready);
        end
        next_cycle();
        set_iss(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        checks++;
        if (busy_mask !== 32'h0000_0040 || rf_we !== 1'b0 || rf_rd !== 5'd5) begin
            failures++;
            $display("FAIL raw_after: busy=%h we=%b rd=%0d want 00000040 0 5", busy_mask, rf_we, rf_rd);
        end
        set_mem(1'b1, 5'd6, 32'h66);
        next_cycle();
        drive_idle();
    endtask

    task automatic test_priority();
        set_alu(1'b1, 5'd3, 32'h3333);
        set_mem(1'b1, 5'd4, 32'h4444);
        settle();
        checks++;
        if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin
            failures++;
            $display("FAIL prio_grant: mem_ready=%b alu_ready=%b want 1 0", mem_ready, alu_ready);
        end
        next_cycle();
        set_mem(1'b0, 5'd0, 32'h0);
        checks++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd4 || rf_wdata !== 32'h4444) begin
            failures++;
            $display("FAIL prio_mem_write: we=%b rd=%0d wd=%h want 1 4 4444", rf_we, rf_rd, rf_wdata);
        end
        settle();
        checks++;
        if (alu_ready !== 1'b1) begin
            failures++;
            $display("FAIL prio_alu_next: alu_ready=%b want 1", alu_ready);
        end
        next_cycle();
        drive_idle();
        checks++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd3 || rf_wdata !== 32'h3333) begin
            failures++;
            $display("FAIL prio_alu_write: we=%b rd=%0d wd=%h want 1 3 3333", rf_we, rf_rd, rf_wdata);
        end
        next_cycle();
    endtask

    task automatic test_starvation();
        set_alu(1'b1, 5'd11, 32'hA11A);
        for (int k = 1; k <= SLIM + 2; k++) begin
            set_mem(1'b1, 5'd10, 32'h1000 + k);
            settle();
            checks++;
            if (k <= SLIM) begin
                if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL starve_wait_%0d: mem_ready=%b alu_ready=%b want 1 0", k, mem_ready, alu_ready);
                end
            end else if (k == SLIM + 1) begin
                if (mem_ready !== 1'b0 || alu_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL starve_override: mem_ready=%b alu_ready=%b want 0 1", mem_ready, alu_ready);
                end
            end else begin
                if (mem_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL starve_mem_resume: mem_ready=%b want 1", mem_ready);
                end
            end
            next_cycle();
            if (k == SLIM + 1) begin
                set_alu(1'b0, 5'd0, 32'h0);
                checks++;
                if (rf_rd !== 5'd11 || rf_wdata !== 32'hA11A || rf_we !== 1'b1) begin
                    failures++;
                    $display("FAIL starve_alu_write: we=%b rd=%0d wd=%h want 1 11 a11a", rf_we, rf_rd, rf_wdata);
                end
            end
        end
        drive_idle();
        next_cycle();
    endtask

    task automatic test_x0();
        set_alu(1'b1, 5'd0, 32'h1234);
        settle();
        checks++;
        if (alu_ready !== 1'b1) begin
            failures++;
            $display("FAIL x0_grant: alu_ready=%b want 1", alu_ready);
        end
        next_cycle();
        set_alu(1'b0, 5'd0, 32'h0);
        checks++;
        if (rf_we !== 1'b0 || busy_mask !== '0) begin
            failures++;
            $display("FAIL x0_write: we=%b busy=%h want 0 0", rf_we, busy_mask);
        end
        set_iss(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
        next_cycle();
        checks++;
        if (busy_mask !== '0) begin
            failures++;
            $display("FAIL x0_issue_busy: busy=%h want 0", busy_mask);
        end
        set_iss(1'b1, 5'd0, 5'd0, 5'd8, 1'b0);
        settle();
        checks++;
        if (iss_ready !== 1'b1) begin
            failures++;
            $display("FAIL x0_read: iss_ready=%b want 1", iss_ready);
        end
        next_cycle();
        drive_idle();
    endtask

    task automatic test_set_clear();
        set_iss(1'b1, 5'd0, 5'd0, 5'd9, 1'b1);
        next_cycle();
        set_iss(1'b1, 5'd1, 5'd2, 5'd7, 1'b1);
        set_alu(1'b1, 5'd9, 32'h9999);
        settle();
        checks++;
        if (iss_ready !== 1'b1 || alu_ready !== 1'b1) begin
            failures++;
            $display("FAIL setclr_ready: iss_ready=%b alu_ready=%b want 1 1", iss_ready, alu_ready);
        end
        next_cycle();
        drive_idle();
        checks++;
        if (busy_mask !== 32'h0000_0080) begin
            failures++;
            $display("FAIL setclr_busy: busy=%h want 00000080", busy_mask);
        end
        set_mem(1'b1, 5'd7, 32'h7777);
        next_cycle();
        drive_idle();
        checks++;
        if (busy_mask !== '0) begin
            failures++;
            $display("FAIL setclr_cleanup: busy=%h want 0", busy_mask);
        end
    endtask

    // ---------------- random test against a behavioural model ----------------
    bit [NREG-1:0] m_busy;
    int            m_wait;       // consecutive cycles the ALU has waited so far
    logic [AW-1:0] m_last_rd;
    logic [DW-1:0] m_last_data;

    function automatic bit is_busy(input logic [AW-1:0] r);
        return (r != 0) && m_busy[r];
    endfunction

    function automatic logic [AW-1:0] pick_rd();
        if (m_busy != 0 && $urandom_range(0, 3) != 0) begin
            for (int t = 0; t < 64; t++) begin
                int r;
                r = $urandom_range(1, NREG - 1);
                if (m_busy[r]) return AW'(r);
            end
        end
        return AW'($urandom_range(0, NREG - 1));
    endfunction

    task automatic test_random();
        bit hold_iss, hold_alu, hold_mem;
        bit e_iss, e_alu, e_mem, ov;
        logic [EW-1:0] e;
        m_busy = '0; m_wait = 0; m_last_rd = '0; m_last_data = '0;
        hold_iss = 0; hold_alu = 0; hold_mem = 0;
        exp_q.delete();
        drive_idle();
        rst_n = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!hold_iss) begin
                set_iss($urandom_range(0, 9) < 7,
                        AW'($urandom_range(0, NREG - 1)), AW'($urandom_range(0, NREG - 1)),
                        AW'($urandom_range(0, NREG - 1)), $urandom_range(0, 1) == 1);
            end
            if (!hold_alu) set_alu($urandom_range(0, 1) == 1, pick_rd(), $urandom);
            if (!hold_mem) set_mem($urandom_range(0, 9) < 6, pick_rd(), $urandom);
            settle();

            // ALU is served when MEM is absent or it has waited long enough;
            // MEM is held off for the whole cycle once the wait limit is hit.
            ov    = (m_wait >= SLIM);
            e_alu = alu_valid && (!mem_valid || ov);
            e_mem = mem_valid && !ov;
            e_iss = iss_valid && !is_busy(iss_rs1) && !is_busy(iss_rs2) && !(iss_wr && is_busy(iss_rd));

            checks++;
            if (iss_ready !== e_iss || alu_ready !== e_alu || mem_ready !== e_mem) begin
                failures++;
                $display("FAIL rand_ready cyc=%0d: iss/alu/mem=%b%b%b want %b%b%b",
                         cyc, iss_ready, alu_ready, mem_ready, e_iss, e_alu, e_mem);
            end

            if (e_mem) begin
                exp_q.push_back({mem_rd != 0, mem_rd, mem_data});
                if (mem_rd != 0) m_busy[mem_rd] = 1'b0;
            end else if (e_alu) begin
                exp_q.push_back({alu_rd != 0, alu_rd, alu_data});
                if (alu_rd != 0) m_busy[alu_rd] = 1'b0;
            end
            if (e_iss && iss_wr && iss_rd != 0) m_busy[iss_rd] = 1'b1;
            if (alu_valid && !e_alu) m_wait = (m_wait < SLIM) ? m_wait + 1 : SLIM;
            else m_wait = 0;

            hold_iss = iss_valid && !e_iss;
            hold_alu = alu_valid && !e_alu;
            hold_mem = mem_valid && !e_mem;

            next_cycle();
            checks++;
            if (busy_mask !== m_busy) begin
                failures++;
                $display("FAIL rand_busy cyc=%0d: busy=%h want %h", cyc, busy_mask, m_busy);
            end
            checks++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                m_last_rd   = e[DW +: AW];
                m_last_data = e[DW-1:0];
                if (rf_we !== e[EW-1] || rf_rd !== m_last_rd || rf_wdata !== m_last_data) begin
                    failures++;
                    $display("FAIL rand_write cyc=%0d: we=%b rd=%0d wd=%h want %b %0d %h",
                             cyc, rf_we, rf_rd, rf_wdata, e[EW-1], m_last_rd, m_last_data);
                end
            end else if (rf_we !== 1'b0 || rf_rd !== m_last_rd || rf_wdata !== m_last_data) begin
                failures++;
                $display("FAIL rand_idle cyc=%0d: we=%b rd=%0d wd=%h want 0 %0d %h",
                         cyc, rf_we, rf_rd, rf_wdata, m_last_rd, m_last_data);
            end
        end
        drive_idle();
        next_cycle();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        drive_idle();
        test_reset();
        test_raw_stall();
        test_priority();
        test_starvation();
        test_x0();
        test_set_clear();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_wb_scoreboard.md
Name: regfile_wb_scoreboard

Overview:
- Controller in front of the 32x32 register file.
- Arbitrates the single register-file write port between the ALU and the memory/load writeback paths.
- Tracks pending destination registers in a busy scoreboard and stalls instruction issue on RAW/WAW hazards.
- Drives the register file's write-enable, destination-address and write-data inputs from registered outputs.

Parameters:
- NREG, 32, number of architectural registers (index 0 is hard-wired zero).
- AW, 5, register address width; clog2(NREG).
- DW, 32, data width.
- STARVE_LIMIT, 4, consecutive ALU-blocked cycles before the ALU overrides MEM priority (1..15).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- iss_valid  in  1  decode presents an instruction for issue.
- iss_ready  out  1  issue accepted this cycle (combinational).
- iss_rs1  in  AW  source register 1.
- iss_rs2  in  AW  source register 2.
- iss_rd  in  AW  destination register.
- iss_wr  in  1  instruction writes iss_rd.
- alu_valid  in  1  ALU writeback request.
- alu_ready  out  1  ALU writeback granted (combinational).
- alu_rd  in  AW  ALU destination.
- alu_data  in  DW  ALU result.
- mem_valid  in  1  load writeback request.
- mem_ready  out  1  load writeback granted (combinational).
- mem_rd  in  AW  load destination.
- mem_data  in  DW  load data.
- rf_we  out  1  register-file write enable (registered).
- rf_rd  out  AW  register-file write address (registered).
- rf_wdata  out  DW  register-file write data (registered).
- busy_mask  out  NREG  current scoreboard, bit i = register i pending.

Behaviour:
- Reset (async assert, sync release): busy_mask=0, rf_we=0, rf_rd=0, rf_wdata=0, starve counter=0.
- Reset is honoured mid-operation; pending busy bits are discarded.
- Handshakes: a transfer fires when valid && ready. Upstream holds its payload stable while valid && !ready.
- Arbitration, one grant per cycle:
  - Default: MEM has priority. mem_ready = mem_valid && !alu_override; alu_ready = alu_valid && !(mem_valid && !alu_override).
  - alu_override = (starve_cnt == STARVE_LIMIT).
  - starve_cnt increments (saturating at STARVE_LIMIT) each cycle alu_valid && !alu_ready.
  - starve_cnt clears on ALU grant, or when alu_valid=0.
- Write port timing:
  - On a granted transfer, the next posedge registers rf_we=(rd!=0), rf_rd=rd, rf_wdata=data.
  - With no grant, rf_we=0 next cycle and rf_rd/rf_wdata hold their values.
  - The register file commits on the following negedge, so total latency is grant posedge + half cycle.
- Scoreboard:
  - Issue fire with iss_wr=1 and iss_rd!=0 sets busy[iss_rd] at posedge.
  - Writeback grant with rd!=0 clears busy[rd] at the same posedge the rf_* outputs are loaded.
  - A write to a register that is not busy is legal; no error and no state change.
  - busy[0] is constant 0.
- Issue check, using registered busy only (no same-cycle bypass of a clear):
  - iss_ready = iss_valid && !busy[iss_rs1] && !busy[iss_rs2] && !(iss_wr && busy[iss_rd]).
  - Register x0 never stalls.
- Simultaneous events:
  - Set and clear of different registers both apply.
  - Set and clear of the same register: set wins. WAW stalling makes this unreachable legally; the rule exists for robustness.
- Visibility: a reader issued the cycle after the clear samples the register file at the next posedge, after the negedge commit, so it sees the new value.
- No combinational path from iss_* to alu/mem ready or the reverse.

Decomposition:
- Shared package constants: NREG, AW, DW, REG_ZERO = 0.
- Shared package typedef: wb_req_t {valid, rd, data}.
- One natural sub-module: wb_arbiter (two-requester priority arbiter with starvation counter, producing grants and the muxed rd/data).
- Scoreboard and output registers live in the top level.

Test Plan:
- Reset, then idle → busy_mask=0, rf_we=0. Assert rst_n=0 mid-stream with busy_mask=0x0000_0006 → busy_mask=0 and rf_we=0 immediately, without waiting for a clock edge.
- Issue rd=5 (iss_wr=1), then next cycle issue rs1=5 → busy_mask bit5=1 and the second issue sees iss_ready=0.
  - Then ALU writes rd=5 data=0xDEADBEEF → alu_ready=1; next cycle rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF, busy bit5=0, and the stalled issue sees iss_ready=1.
- ALU and MEM both valid one cycle (alu rd=3, mem rd=4) → mem_ready=1, alu_ready=0; rf_rd=4, then rf_rd=3 the following cycle.
- MEM held valid continuously with ALU valid, STARVE_LIMIT=4 → ALU granted on its 5th waiting cycle, mem_ready=0 that cycle, MEM resumes next cycle.
- Writeback rd=0 data=0x1234 → grant given, next cycle rf_we=0. Issue rd=0 iss_wr=1 → busy_mask unchanged, and a later rs1=0 issue has iss_ready=1.
- Issue rd=7 in the same cycle an ALU writeback to rd=9 is granted (busy bit9 set beforehand) → next busy_mask has bit7=1 and bit9=0.
